// File: rtl/pci_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pci_pkg -- PCI I/O target command codes, FSM states, active-low levels. Rev 1.0
// ---------------------------------------------------------------------------
package pci_pkg;

  localparam logic [3:0] CMD_IORD = 4'b0010;
  localparam logic [3:0] CMD_IOWR = 4'b0011;

  localparam logic OE_ON    = 1'b0;
  localparam logic OE_OFF   = 1'b1;
  localparam logic ASSERT_N = 1'b0;
  localparam logic IDLE_N   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUSY  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RDLAT = 3'd3,
    ST_XFER  = 3'd4,
    ST_STOPW = 3'd5,
    ST_TURN  = 3'd6
  } state_t;

  function automatic logic is_io_cmd(input logic [3:0] cmd);
    return (cmd == CMD_IORD) || (cmd == CMD_IOWR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pci_par_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pci_par_gen -- even parity over AD/CBE plus its output enable, one cycle late. Rev 1.0
// ---------------------------------------------------------------------------
module pci_par_gen
  import pci_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ad,
  input  logic [3:0]  cbe,
  input  logic        oe_ad_n,
  output logic        par,
  output logic        oe_par_n
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par      <= 1'b0;
      oe_par_n <= OE_OFF;
    end else begin
      par      <= ^{ad, cbe};
      oe_par_n <= oe_ad_n;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pci_io_target_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pci_io_target_seq -- single-data-phase PCI I/O target with a register-bus side. Rev 1.0
// ---------------------------------------------------------------------------
module pci_io_target_seq
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0200,
  parameter int          ADDR_BITS   = 4,
  parameter int          WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_i_n,
  input  logic                 irdy_i_n,
  input  logic [31:0]          ad_i,
  input  logic [3:0]           cbe_i,
  output logic [31:0]          ad_o,
  output logic [3:0]           oe_ad_n,
  output logic                 par_o,
  output logic                 oe_par_n,
  output logic                 devsel_o_n,
  output logic                 oe_devsel_n,
  output logic                 trdy_o_n,
  output logic                 oe_trdy_n,
  output logic                 stop_o_n,
  output logic                 oe_stop_n,
  output logic [ADDR_BITS-3:0] reg_addr,
  output logic [3:0]           reg_be,
  output logic                 reg_we,
  output logic [31:0]          reg_wdata,
  output logic                 reg_re,
  input  logic [31:0]          reg_rdata
);

  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [2:0] WAIT_INIT = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t               state, state_nx;
  logic [2:0]           wait_cnt, cnt_nx;
  logic                 is_rd, rd_nx;
  logic                 oe_ctl_n, oe_ctl_nx;
  logic                 oe_ad_q, oe_ad_nx;
  logic                 devsel_nx, trdy_nx, stop_nx, we_nx, re_nx;
  logic [31:0]          ad_nx, wdata_nx;
  logic [3:0]           be_nx;
  logic [ADDR_BITS-3:0] addr_nx;
  logic                 hit;

  assign hit = (ad_i[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]) && is_io_cmd(cbe_i);

  always_comb begin
    state_nx  = state;
    cnt_nx    = wait_cnt;
    rd_nx     = is_rd;
    oe_ctl_nx = oe_ctl_n;
    oe_ad_nx  = oe_ad_q;
    devsel_nx = devsel_o_n;
    trdy_nx   = trdy_o_n;
    stop_nx   = stop_o_n;
    ad_nx     = ad_o;
    addr_nx   = reg_addr;
    wdata_nx  = reg_wdata;
    be_nx     = reg_be;
    we_nx     = 1'b0;
    re_nx     = 1'b0;
    case (state)
      ST_IDLE: begin
        // FRAME# low while IRDY# still low is the tail of someone else's transaction
        if (!frame_i_n) begin
          if (irdy_i_n && hit) begin
            devsel_nx = ASSERT_N;
            oe_ctl_nx = OE_ON;
            addr_nx   = ad_i[ADDR_BITS-1:2];
            rd_nx     = (cbe_i == CMD_IORD);
            if (cbe_i == CMD_IORD) begin
              re_nx    = 1'b1;
              state_nx = ST_RDLAT;
            end else if (HAS_WAIT) begin
              cnt_nx   = WAIT_INIT;
              state_nx = ST_WAIT;
            end else begin
              trdy_nx  = ASSERT_N;
              stop_nx  = frame_i_n;
              state_nx = ST_XFER;
            end
          end else begin
            state_nx = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (frame_i_n && irdy_i_n) state_nx = ST_IDLE;
      end
      ST_RDLAT: begin
        ad_nx    = reg_rdata;
        oe_ad_nx = OE_ON;
        if (HAS_WAIT) begin
          cnt_nx   = WAIT_INIT;
          state_nx = ST_WAIT;
        end else begin
          trdy_nx  = ASSERT_N;
          stop_nx  = frame_i_n;
          state_nx = ST_XFER;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 3'd0) begin
          trdy_nx  = ASSERT_N;
          stop_nx  = frame_i_n;
          state_nx = ST_XFER;
        end else begin
          cnt_nx = wait_cnt - 3'd1;
        end
      end
      ST_XFER: begin
        if (!irdy_i_n) begin
          if (!is_rd) begin
            we_nx    = 1'b1;
            wdata_nx = ad_i;
            be_nx    = ~cbe_i;
          end
          if (frame_i_n) begin
            devsel_nx = IDLE_N;
            trdy_nx   = IDLE_N;
            stop_nx   = IDLE_N;
            oe_ad_nx  = OE_OFF;
            state_nx  = ST_TURN;
          end else begin
            trdy_nx  = IDLE_N;
            stop_nx  = ASSERT_N;
            state_nx = ST_STOPW;
          end
        end
      end
      ST_STOPW: begin
        if (frame_i_n) begin
          devsel_nx = IDLE_N;
          trdy_nx   = IDLE_N;
          stop_nx   = IDLE_N;
          oe_ad_nx  = OE_OFF;
          state_nx  = ST_TURN;
        end
      end
      ST_TURN: begin
        oe_ctl_nx = OE_OFF;
        oe_ad_nx  = OE_OFF;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= 3'd0;
      is_rd      <= 1'b0;
      oe_ctl_n   <= OE_OFF;
      oe_ad_q    <= OE_OFF;
      devsel_o_n <= IDLE_N;
      trdy_o_n   <= IDLE_N;
      stop_o_n   <= IDLE_N;
      ad_o       <= 32'd0;
      reg_addr   <= '0;
      reg_wdata  <= 32'd0;
      reg_be     <= 4'd0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
    end else begin
      state      <= state_nx;
      wait_cnt   <= cnt_nx;
      is_rd      <= rd_nx;
      oe_ctl_n   <= oe_ctl_nx;
      oe_ad_q    <= oe_ad_nx;
      devsel_o_n <= devsel_nx;
      trdy_o_n   <= trdy_nx;
      stop_o_n   <= stop_nx;
      ad_o       <= ad_nx;
      reg_addr   <= addr_nx;
      reg_wdata  <= wdata_nx;
      reg_be     <= be_nx;
      reg_we     <= we_nx;
      reg_re     <= re_nx;
    end
  end

  assign oe_devsel_n = oe_ctl_n;
  assign oe_trdy_n   = oe_ctl_n;
  assign oe_stop_n   = oe_ctl_n;
  assign oe_ad_n     = {4{oe_ad_q}};

  pci_par_gen u_par_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .ad       (ad_o),
    .cbe      (cbe_i),
    .oe_ad_n  (oe_ad_q),
    .par      (par_o),
    .oe_par_n (oe_par_n)
  );

endmodule
`default_nettype wire
